// File: rtl/psum_ofifo_if.sv
// psum_ofifo_if: bundle between the MAC column row and the psum output FIFO.
//   master : producer/consumer side (drives in/wr/rd, observes row + flags)
//   slave  : the FIFO (consumes in/wr/rd, drives out + flags)
// Signals:
//   in          col*bw_psum  packed per-lane partial sums, lane i at [i*bw_psum +: bw_psum]
//   wr          col          per-lane write strobe
//   rd          1            pop one aligned row
//   out         col*bw_psum  head entry of every lane (zero when no full row)
//   o_valid     1            every lane non-empty
//   o_full      1            at least one lane full
//   o_empty     1            every lane empty
//   o_overflow  1            sticky: a write was dropped
//   o_underflow 1            sticky: rd seen without a complete row
interface psum_ofifo_if #(
  parameter int col     = 8,
  parameter int bw_psum = 22
);
  logic [col*bw_psum-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*bw_psum-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_empty;
  logic                   o_overflow;
  logic                   o_underflow;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_empty, o_overflow, o_underflow
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_empty, o_overflow, o_underflow
  );
endinterface

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column partial-sum FIFOs that absorb the column-to-column
// write skew and present one column-aligned row to the downstream writer.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (clears pointers and sticky flags)
//   bus    psum_ofifo_if.slave (in/wr/rd in, out + status flags out)
// A row is only poppable when every lane holds an entry; all lanes pop
// together, so a single shared read pointer serves every lane.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw_psum = 22,
  parameter int depth   = 16
) (
  input  logic        clk,
  input  logic        reset,
  psum_ofifo_if.slave bus
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q [col];
  logic [PW-1:0] wptr_d [col];
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] rptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic signed [bw_psum-1:0] mem_q [col][depth];

  logic [col-1:0] lane_full;
  logic [col-1:0] lane_empty;
  logic [col-1:0] wr_ok;
  logic           valid;
  logic           pop;

  // Lane status is purely a function of the pointers.
  always_comb begin
    for (int i = 0; i < col; i++) begin
      lane_empty[i] = (wptr_q[i] == rptr_q);
      lane_full[i]  = (wptr_q[i][AW] != rptr_q[AW]) &&
                      (wptr_q[i][AW-1:0] == rptr_q[AW-1:0]);
    end
    valid = ~|lane_empty;
    pop   = bus.rd & valid;
    // A full lane still accepts a write when the same edge pops its head.
    wr_ok = bus.wr & (~lane_full | {col{pop}});
  end

  always_comb begin
    for (int i = 0; i < col; i++) begin
      wptr_d[i] = wptr_q[i] + PW'(wr_ok[i]);
    end
    rptr_d = rptr_q + PW'(pop);
    ovf_d  = ovf_q | (|(bus.wr & ~wr_ok));
    unf_d  = unf_q | (bus.rd & ~valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) begin
        wptr_q[i] <= '0;
      end
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        wptr_q[i] <= wptr_d[i];
      end
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_ok[i]) begin
        mem_q[i][wptr_q[i][AW-1:0]] <= bus.in[i*bw_psum +: bw_psum];
      end
    end
  end

  // First-word-fall-through row, forced to zero until every lane has data.
  always_comb begin
    bus.out = '0;
    for (int i = 0; i < col; i++) begin
      if (valid) begin
        bus.out[i*bw_psum +: bw_psum] = mem_q[i][rptr_q[AW-1:0]];
      end
    end
    bus.o_valid     = valid;
    bus.o_full      = |lane_full;
    bus.o_empty     = &lane_empty;
    bus.o_overflow  = ovf_q;
    bus.o_underflow = unf_q;
  end

endmodule

// File: tb/tb_psum_ofifo.sv
module tb_psum_ofifo;

  localparam int COL   = 8;
  localparam int BW    = 22;
  localparam int DEPTH = 16;
  localparam int VW    = COL*BW + 5;

  logic clk;
  logic reset;

  psum_ofifo_if #(.col(COL), .bw_psum(BW)) ifc ();

  psum_ofifo #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per lane plus sticky flags.
  logic [BW-1:0] mq [COL][$];
  logic          m_ovf;
  logic          m_unf;

  logic [VW-1:0] obs;
  assign obs = {ifc.out, ifc.o_valid, ifc.o_full, ifc.o_empty,
                ifc.o_overflow, ifc.o_underflow};

  function automatic bit m_valid();
    for (int i = 0; i < COL; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [COL*BW-1:0] o;
    bit full, empty;
    o = '0;
    full = 1'b0;
    empty = 1'b1;
    for (int i = 0; i < COL; i++) begin
      if (mq[i].size() == DEPTH) full = 1'b1;
      if (mq[i].size() != 0) empty = 1'b0;
    end
    if (m_valid()) for (int i = 0; i < COL; i++) o[i*BW +: BW] = mq[i][0];
    return {o, m_valid(), full, empty, m_ovf, m_unf};
  endfunction

  function automatic logic [COL*BW-1:0] fill(input logic [BW-1:0] v);
    logic [COL*BW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  function automatic logic [BW-1:0] lane(input int i);
    return ifc.out[i*BW +: BW];
  endfunction

  // One clock: drive, decide from pre-edge model state, update after edge.
  task automatic step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
    bit pop;
    bit acc [COL];
    ifc.wr = w;
    ifc.in = d;
    ifc.rd = r;
    pop = r && m_valid();
    for (int i = 0; i < COL; i++) begin
      acc[i] = w[i] && (mq[i].size() < DEPTH || pop);
    end
    @(posedge clk);
    #1;
    if (pop) for (int i = 0; i < COL; i++) void'(mq[i].pop_front());
    for (int i = 0; i < COL; i++) begin
      if (acc[i]) mq[i].push_back(d[i*BW +: BW]);
      else if (w[i]) m_ovf = 1'b1;
    end
    if (r && !pop) m_unf = 1'b1;
    ifc.wr = '0;
    ifc.rd = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < COL; i++) mq[i].delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    ifc.wr = '0;
    ifc.rd = 1'b0;
    ifc.in = '0;
    do_reset();
    checks++;
    if (obs !== {{(COL*BW){1'b0}}, 5'b00100}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs, {{(COL*BW){1'b0}}, 5'b00100});
    end
  endtask

  task automatic test_skew();
    logic [COL*BW-1:0] d;
    do_reset();
    for (int i = 0; i < COL; i++) begin
      d = '0;
      d[i*BW +: BW] = BW'(100*i + 1);
      step(COL'(1) << i, d, 1'b0);
      checks++;
      if (ifc.o_valid !== (i == COL-1)) begin
        errors++;
        $display("FAIL skew_valid lane=%0d got=%b want=%b", i, ifc.o_valid, (i == COL-1));
      end
    end
    for (int i = 0; i < COL; i++) begin
      checks++;
      if (lane(i) !== BW'(100*i + 1)) begin
        errors++;
        $display("FAIL skew_out lane=%0d got=%0d want=%0d", i, lane(i), 100*i + 1);
      end
    end
    step('0, '0, 1'b1);
    checks++;
    if (ifc.o_empty !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL skew_pop_empty got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_fill_full();
    logic [COL-1:0] lane3;
    do_reset();
    for (int k = 0; k < DEPTH; k++) step('1, fill(BW'(k)), 1'b0);
    checks++;
    if (ifc.o_full !== 1'b1 || ifc.o_valid !== 1'b1 || ifc.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_flags got full=%b valid=%b ovf=%b want 1 1 0",
               ifc.o_full, ifc.o_valid, ifc.o_overflow);
    end
    lane3 = '0;
    lane3[3] = 1'b1;
    step(lane3, fill(BW'(55)), 1'b0);
    checks++;
    if (ifc.o_overflow !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL overflow got=%h want=%h", obs, exp_vec());
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (ifc.out !== fill(BW'(k))) begin
        errors++;
        $display("FAIL drain_order idx=%0d got=%h want=%h", k, ifc.out, fill(BW'(k)));
      end
      step('0, '0, 1'b1);
    end
    checks++;
    if (obs !== exp_vec() || ifc.o_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_end got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_wrpop_full();
    do_reset();
    for (int k = 0; k < DEPTH; k++) step('1, fill(BW'(k)), 1'b0);
    step('1, fill(BW'(99)), 1'b1);
    checks++;
    if (ifc.out !== fill(BW'(1)) || ifc.o_full !== 1'b1 || ifc.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrpop_full got out=%h full=%b ovf=%b want lanes=1 full=1 ovf=0",
               ifc.out, ifc.o_full, ifc.o_overflow);
    end
    for (int k = 0; k < DEPTH-1; k++) step('0, '0, 1'b1);
    checks++;
    if (ifc.out !== fill(BW'(99)) || obs !== exp_vec()) begin
      errors++;
      $display("FAIL wrpop_last got=%h want=%h", ifc.out, fill(BW'(99)));
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(8'h7F, fill(BW'(42)), 1'b0);
    step('0, '0, 1'b1);
    checks++;
    if (ifc.o_underflow !== 1'b1 || ifc.out !== '0 || ifc.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL underflow got unf=%b valid=%b out=%h want 1 0 0",
               ifc.o_underflow, ifc.o_valid, ifc.out);
    end
    // Pointers must not have moved: completing lane 7 exposes the original row.
    step(8'h80, fill(BW'(7)), 1'b0);
    checks++;
    if (lane(0) !== BW'(42) || lane(7) !== BW'(7) || obs !== exp_vec()) begin
      errors++;
      $display("FAIL underflow_ptrs got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step('1, fill(BW'(0)), 1'b0);
    for (int v = 1; v < 40; v++) begin
      step('1, fill(BW'(v)), 1'b1);
      checks++;
      if (ifc.out !== fill(BW'(v)) || ifc.o_full !== 1'b0 || ifc.o_empty !== 1'b0) begin
        errors++;
        $display("FAIL wrap v=%0d got out=%h full=%b empty=%b", v, ifc.out,
                 ifc.o_full, ifc.o_empty);
      end
    end
    step('0, '0, 1'b1);
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL wrap_end got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    logic [COL*BW-1:0] d;
    do_reset();
    step('0, '0, 1'b1);
    for (int k = 0; k < 5; k++) step('1, fill(BW'(10 + k)), 1'b0);
    checks++;
    if (ifc.o_underflow !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL async_pre got=%h want=%h", obs, exp_vec());
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== {{(COL*BW){1'b0}}, 5'b00100}) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", obs, {{(COL*BW){1'b0}}, 5'b00100});
    end
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < COL; i++) d[i*BW +: BW] = BW'(777 + i);
    step('1, d, 1'b0);
    checks++;
    if (ifc.out !== d || obs !== exp_vec()) begin
      errors++;
      $display("FAIL async_after got=%h want=%h", ifc.out, d);
    end
  endtask

  task automatic test_random();
    logic [COL-1:0] w;
    logic [COL*BW-1:0] d;
    logic r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < COL; i++) begin
        w[i] = ($urandom_range(0, 99) < 70);
        d[i*BW +: BW] = BW'($urandom);
      end
      r = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 40 : 85));
      step(w, d, r);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    ifc.wr = '0;
    ifc.rd = 1'b0;
    ifc.in = '0;
    model_clear();
    test_reset();
    test_skew();
    test_fill_full();
    test_wrpop_full();
    test_underflow();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output buffer directly downstream of the row of MAC columns.
- Each column emits one signed partial sum per execute cycle with its own write strobe. The strobes are skewed by one cycle per column because the instruction is pipelined column-to-column.
- The block holds one FIFO per column and presents a column-aligned output row. A row is poppable only once every column has at least one entry, which removes the skew for the downstream normaliser/SRAM writer.

Parameters:
- col, 8, number of MAC columns / FIFO lanes.
- bw_psum, 22, width of one partial sum; two's complement.
- depth, 16, entries per lane; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low clears all state immediately, independent of clk.
- in  input  col*bw_psum  psum from each column; lane i is bits [(i+1)*bw_psum-1 : i*bw_psum].
- wr  input  col  per-lane write strobe; wr[i] comes from column i's fifo_wr.
- rd  input  1  pop one aligned row.
- out  output  col*bw_psum  head entry of every lane, same lane packing as in.
- o_valid  output  1  every lane is non-empty.
- o_full  output  1  at least one lane is full.
- o_empty  output  1  every lane is empty.
- o_overflow  output  1  sticky: a write was dropped.
- o_underflow  output  1  sticky: rd was asserted while o_valid was low.

Behaviour:
- Reset values (while reset is low and after release):
  - All read/write pointers are 0.
  - o_valid=0, o_full=0, o_empty=1, o_overflow=0, o_underflow=0, out=0.
  - Storage contents are not reset.
- Reset asserted mid-operation discards all buffered data in that instant. The first write after release lands in entry 0.
- Each lane is a circular buffer with log2(depth)+1-bit read and write pointers.
  - Full when the pointer MSBs differ and the remaining bits are equal.
  - Empty when the pointers are equal.
  - Pointers wrap modulo 2*depth; the address is the low log2(depth) bits.
- Write, lane i:
  - On a clock edge with wr[i]=1 and (lane not full OR pop this cycle), store in lane i at wptr and increment wptr.
  - With wr[i]=1, the lane full, and no pop: the data is dropped, the pointers are unchanged, and o_overflow is set.
- Pop:
  - pop = rd & o_valid. On pop, every lane's rptr increments together; lanes never pop independently.
  - rd=1 with o_valid=0: no pointer moves and o_underflow is set.
- Simultaneous write and pop on the same lane: both take effect and the occupancy is unchanged. This holds when the lane is full: the write is accepted and the oldest entry leaves.
- Simultaneous write and pop on an empty lane cannot occur, because pop requires every lane to be non-empty.
- Output timing:
  - First-word-fall-through. out shows each lane's entry at rptr combinationally from storage, gated to all zeros when o_valid=0.
  - A written entry is visible on out the cycle after its write edge, provided all other lanes are non-empty.
- Flags are combinational from the pointers. The sticky flags clear only on reset.
- Arithmetic: data is passed through unmodified; no sign extension or saturation.
- Skew handling: with lane i written starting at cycle t+i, o_valid first rises after the edge at t+col-1. Rows leave in write order, with lane alignment by per-lane index.
- Throughput: one write per lane per cycle and one row pop per cycle, sustained indefinitely with no bubbles.

Test Plan:
- Skewed fill: wr[i] pulses at cycle 10+i with in lane i = 100*i+1. o_valid stays 0 until after edge 17, then rises. out lanes read 1, 101, …, 701. rd=1 for one cycle gives o_empty=1.
- Fill to full: write 16 entries per lane with value = index 0..15, no rd. o_full=1 and o_valid=1. A 17th wr on lane 3 sets o_overflow=1. Draining 16 pops returns 0..15 in order on every lane.
- Simultaneous write+pop at full: all lanes full with value 0 at the head. Assert rd and wr[all] with value 99. out shows 1 next cycle, occupancy stays 16, and o_overflow stays 0. After 15 further pops, the last row reads 99.
- Underflow: with lane 7 empty and lanes 0-6 holding one entry, assert rd. Pointers are unchanged, o_underflow=1, out=0.
- Wrap-around: 40 write/pop cycles at steady state with 1 entry in flight, values 0..39 incrementing. Each value pops in order, and the pointers pass 2*depth without glitching o_full or o_empty.
- Async reset mid-stream: with 5 entries buffered, pull reset low between clock edges. o_empty=1, o_valid=0, out=0, and both sticky flags are 0 before the next edge. After release, the first written row reappears intact.
